// File: rtl/alu_bcd_converter.sv
// rtl/alu_bcd_converter.sv - iterative binary-to-BCD converter (double dabble), one step per clock
module alu_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [WIDTH-1:0] bin_reg;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adjusted;
    logic [SW-1:0]   shifted;
    logic [CW-1:0]   cnt;
    logic            last_step;

    // Digit-wise add-3 stays inside each nibble; no carry between digits.
    always_comb begin
        adjusted = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    assign shifted   = {adjusted[SW-2:0], bin_reg[WIDTH-1]};
    assign last_step = (cnt == CW'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_CONVERT;
            S_CONVERT: if (last_step) next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin_reg <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bin_reg <= bin_in;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
                    end
                end
                S_CONVERT: begin
                    scratch <= shifted;
                    bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                    // Output register only moves on the final step, so partial sums never escape.
                    if (last_step) begin
                        bcd_out <= shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu_bcd_converter.sv
// tb/tb_alu_bcd_converter.sv - directed self-checking bench for alu_bcd_converter
module tb_alu_bcd_converter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int n_cmp;
    int n_bad;

    alu_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_conversion(input logic [7:0] v, output logic [11:0] res,
                                  output int lat, output logic busy_after, output int n_done);
        start  = 1'b1;
        bin_in = v;
        @(negedge clock);
        start      = 1'b0;
        busy_after = busy;
        lat        = 0;
        n_done     = 0;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        res = bcd_out;
        if (done) n_done++;
        @(negedge clock);
        if (done) n_done++;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = 8'h00;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b bcd=%h, expected 0 0 000", busy, done, bcd_out);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_max_value();
        logic [11:0] r; int lat; logic b; int nd;
        run_conversion(8'hFF, r, lat, b, nd);
        n_cmp++;
        if (b !== 1'b1) begin n_bad++; $display("FAIL max_busy: busy=%b expected 1", b); end
        n_cmp++;
        if (lat !== 8) begin n_bad++; $display("FAIL max_latency: %0d cycles expected 8", lat); end
        n_cmp++;
        if (r !== 12'h255) begin n_bad++; $display("FAIL max_value: bcd=%h expected 255", r); end
        n_cmp++;
        if (nd !== 1) begin n_bad++; $display("FAIL max_done_count: %0d expected 1", nd); end
    endtask

    task automatic test_boundaries();
        logic [11:0] r; int lat; logic b; int nd;
        run_conversion(8'd100, r, lat, b, nd);
        n_cmp++;
        if (r !== 12'h100) begin n_bad++; $display("FAIL conv_100: bcd=%h expected 100", r); end
        run_conversion(8'd0, r, lat, b, nd);
        n_cmp++;
        if (r !== 12'h000) begin n_bad++; $display("FAIL conv_0: bcd=%h expected 000", r); end
        n_cmp++;
        if (nd !== 1 || lat !== 8) begin
            n_bad++;
            $display("FAIL conv_0_done: pulses=%0d latency=%0d expected 1 and 8", nd, lat);
        end
    endtask

    task automatic test_ignore_start();
        int nd;
        start  = 1'b1;
        bin_in = 8'd37;
        @(negedge clock);
        start  = 1'b0;
        bin_in = 8'd99;
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (done) nd++;
        end
        n_cmp++;
        if (nd !== 1) begin n_bad++; $display("FAIL ignore_start_done_count: %0d expected 1", nd); end
        n_cmp++;
        if (bcd_out !== 12'h037) begin n_bad++; $display("FAIL ignore_start_value: bcd=%h expected 037", bcd_out); end
    endtask

    task automatic test_back_to_back();
        int gap;
        logic [11:0] first;
        start  = 1'b1;
        bin_in = 8'd9;
        @(negedge clock);
        bin_in = 8'd10;
        gap = 0;
        while (!done && gap < 20) begin @(negedge clock); gap++; end
        first = bcd_out;
        n_cmp++;
        if (first !== 12'h009) begin n_bad++; $display("FAIL b2b_first: bcd=%h expected 009", first); end
        gap = 0;
        @(negedge clock); gap++;
        while (!done && gap < 20) begin @(negedge clock); gap++; end
        start = 1'b0;
        n_cmp++;
        if (gap !== 10) begin n_bad++; $display("FAIL b2b_period: %0d cycles expected 10", gap); end
        n_cmp++;
        if (bcd_out !== 12'h010) begin n_bad++; $display("FAIL b2b_second: bcd=%h expected 010", bcd_out); end
        repeat (2) @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_convert();
        logic [11:0] r; int lat; logic b; int nd;
        start  = 1'b1;
        bin_in = 8'd200;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b done=%b bcd=%h expected 0 0 000", busy, done, bcd_out);
        end
        @(negedge clock);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done) nd++;
        end
        n_cmp++;
        if (nd !== 0) begin n_bad++; $display("FAIL reset_mid_no_done: %0d pulses expected 0", nd); end
        run_conversion(8'd200, r, lat, b, nd);
        n_cmp++;
        if (r !== 12'h200) begin n_bad++; $display("FAIL reset_mid_reconvert: bcd=%h expected 200", r); end
    endtask

    task automatic test_sweep();
        logic [11:0] r; int lat; logic b; int nd;
        logic [11:0] exp_v;
        for (int v = 0; v < 256; v++) begin
            exp_v = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            run_conversion(8'(v), r, lat, b, nd);
            n_cmp++;
            if (r !== exp_v || nd !== 1) begin
                n_bad++;
                $display("FAIL sweep_%0d: bcd=%h pulses=%0d expected %h and 1", v, r, nd, exp_v);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_max_value();
        test_boundaries();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_convert();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
